id_stage: RTL
=============

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of register data and operands.
REQ-002 SHALL have parameter REG_NUM, default 32, number of architectural registers (address width 5).
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port inst_i  input  32  instruction from fetch.
REQ-006 SHALL have port inst_valid_i  input  1  inst_i valid.
REQ-007 SHALL have port inst_ready_o  output  1  stage can accept inst_i this cycle.
REQ-008 SHALL have port flush_i  input  1  discard the held instruction.
REQ-009 SHALL have port wb_we_i  input  1  writeback enable from execute result path.
REQ-010 SHALL have port wb_waddr_i  input  5  writeback register address.
REQ-011 SHALL have port wb_wdata_i  input  DATA_WIDTH  writeback data.
REQ-012 SHALL have port ex_valid_o  output  1  operands/instruction to execute are valid.
REQ-013 SHALL have port ex_ready_i  input  1  execute consumes outputs this cycle.
REQ-014 SHALL have port op1_o, op2_o  output  DATA_WIDTH  registered operands.
REQ-015 SHALL have port inst_o  output  32  registered instruction; reg_waddr_o  output  5  registered rd.

Function
REQ-016 SHALL hold a REG_NUM x DATA_WIDTH register file; x0 reads 0, writes to x0 ignored.
REQ-017 SHALL write wb_wdata_i to wb_waddr_i at clock edge when wb_we_i=1.
REQ-018 SHALL drive inst_ready_o = !ex_valid_o || ex_ready_i, combinationally.
REQ-019 SHALL accept when inst_valid_i && inst_ready_o; outputs loaded at that edge, ex_valid_o=1 next cycle (latency 1).
REQ-020 SHALL clear ex_valid_o on ex_ready_i with no accept same cycle; accept+consume same cycle keeps ex_valid_o=1 with new data.
REQ-021 SHALL hold op1_o, op2_o, inst_o, reg_waddr_o stable while ex_valid_o=1 and ex_ready_i=0.
REQ-022 SHALL decode I-type (opcode 0010011): op1=rs1 value, op2=sign-extended inst[31:20]; funct3 001/101: op2=zero-extended inst[24:20].
REQ-023 SHALL decode R-type (opcode 0110011): op1=rs1 value, op2=rs2 value.
REQ-024 SHALL for any other opcode: op1=op2=0, inst passed unchanged, ex_valid_o set normally.
REQ-025 SHALL set reg_waddr_o=inst[11:7] for every accepted instruction.
REQ-026 SHALL capture operands at acceptance; later writebacks do not update held operands.
REQ-027 SHALL on flush_i=1: next cycle ex_valid_o=0, inst_o=0x00000013, op1_o=op2_o=0, reg_waddr_o=0; flush overrides same-cycle accept; register file writes still occur.

Reset
REQ-028 SHALL on rst_i=1 at edge: ex_valid_o=0, op1_o=op2_o=0, inst_o=0x00000013, reg_waddr_o=0, all registers 0.
REQ-029 SHALL hold inst_ready_o=1 during reset cycles (follows from ex_valid_o=0) but ignore inst_valid_i while rst_i=1.
REQ-030 SHALL give reset priority over flush, accept and writeback; reset mid-hold drops the held instruction.

Configuration
REQ-031 SHALL, with ID_BYPASS_EN defined, forward wb_wdata_i to a read of wb_waddr_i (non-zero) in the same cycle as accept.
REQ-032 SHALL, without ID_BYPASS_EN, capture the pre-write register value on same-cycle read/write collision.

Structure
REQ-033 SHALL take opcodes, funct3 codes, NOP encoding, ZERO, widths from the shared defines package.
REQ-034 SHALL instantiate sub-module id_regfile (two async read ports, one sync write port, synchronous reset, bypass under ID_BYPASS_EN).

Verification
REQ-035 SHALL cover: write x5=0x10 then accept ADDI x6,x5,-1 (0xFFF28313) -> op1_o=0x10, op2_o=0xFFFFFFFF, reg_waddr_o=6, ex_valid_o=1 next cycle.
REQ-036 SHALL cover: SRAI x1,x2,3 (0x40315093) -> op2_o=0x3, inst_o=0x40315093.
REQ-037 SHALL cover: ex_ready_i=0 for 3 cycles with inst_valid_i=1 -> inst_ready_o=0, outputs unchanged; ex_ready_i=1 -> next instruction loaded following cycle.
REQ-038 SHALL cover: write x0=0xDEAD then ADD x1,x0,x0 -> op1_o=op2_o=0.
REQ-039 SHALL cover: same-cycle wb x7=0x55 and accept ADDI x8,x7,0 -> op1_o=0x55 with ID_BYPASS_EN, old x7 value without.
REQ-040 SHALL cover: flush_i=1 with accept same cycle -> ex_valid_o=0, inst_o=0x00000013; rst_i mid-hold -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/id_stage_pkg.sv
// Shared decode constants and helpers for the instruction decode stage.
// Configuration: define ID_BYPASS_EN to forward same-cycle writeback data.
package id_stage_pkg;

   localparam int INST_W = 32;
   localparam int REG_AW = 5;

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SRL_SRA = 3'b101;

   localparam logic [INST_W-1:0] INST_NOP = 32'h0000_0013;
   localparam logic [REG_AW-1:0] ZERO     = '0;

   typedef enum logic [1:0] {
      DEC_ITYPE,
      DEC_RTYPE,
      DEC_OTHER
   } dec_e;

   function automatic dec_e decode(input logic [INST_W-1:0] inst);
      if (inst[6:0] == OPC_OP_IMM) return DEC_ITYPE;
      if (inst[6:0] == OPC_OP)     return DEC_RTYPE;
      return DEC_OTHER;
   endfunction

   function automatic logic is_shift(input logic [2:0] f3);
      return (f3 == F3_SLL) || (f3 == F3_SRL_SRA);
   endfunction

endpackage

// File: rtl/id_regfile.sv
// Register file: two async read ports, one sync write port, sync reset.
// Configuration: ID_BYPASS_EN forwards write data onto a matching read.
module id_regfile
   import id_stage_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int REG_NUM    = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [REG_AW-1:0]     raddr1_i,
   input  logic [REG_AW-1:0]     raddr2_i,
   output logic [DATA_WIDTH-1:0] rdata1_o,
   output logic [DATA_WIDTH-1:0] rdata2_o,
   input  logic                  we_i,
   input  logic [REG_AW-1:0]     waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i
);

   logic [DATA_WIDTH-1:0] regs [REG_NUM];
   logic                  byp1;
   logic                  byp2;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < REG_NUM; i++) begin
            regs[i] <= '0;
         end
      end else if (we_i && (waddr_i != ZERO)) begin
         regs[waddr_i] <= wdata_i;
      end
   end

`ifdef ID_BYPASS_EN
   assign byp1 = we_i && (waddr_i == raddr1_i) && (raddr1_i != ZERO);
   assign byp2 = we_i && (waddr_i == raddr2_i) && (raddr2_i != ZERO);
`else
   assign byp1 = 1'b0;
   assign byp2 = 1'b0;
`endif

   always_comb begin
      rdata1_o = '0;
      rdata2_o = '0;
      if (byp1) begin
         rdata1_o = wdata_i;
      end else if (raddr1_i != ZERO) begin
         rdata1_o = regs[raddr1_i];
      end
      if (byp2) begin
         rdata2_o = wdata_i;
      end else if (raddr2_i != ZERO) begin
         rdata2_o = regs[raddr2_i];
      end
   end

endmodule

// File: rtl/id_stage.sv
// Decode stage: reads operands, decodes I/R-type, registers the bundle to execute.
// Configuration: ID_BYPASS_EN enables writeback-to-read forwarding in id_regfile.
module id_stage
   import id_stage_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int REG_NUM    = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [INST_W-1:0]     inst_i,
   input  logic                  inst_valid_i,
   output logic                  inst_ready_o,
   input  logic                  flush_i,
   input  logic                  wb_we_i,
   input  logic [REG_AW-1:0]     wb_waddr_i,
   input  logic [DATA_WIDTH-1:0] wb_wdata_i,
   output logic                  ex_valid_o,
   input  logic                  ex_ready_i,
   output logic [DATA_WIDTH-1:0] op1_o,
   output logic [DATA_WIDTH-1:0] op2_o,
   output logic [INST_W-1:0]     inst_o,
   output logic [REG_AW-1:0]     reg_waddr_o
);

   logic [DATA_WIDTH-1:0] rs1_data;
   logic [DATA_WIDTH-1:0] rs2_data;
   logic [DATA_WIDTH-1:0] op1_d;
   logic [DATA_WIDTH-1:0] op2_d;
   logic                  accept;
   dec_e                  dec;

   id_regfile #(
      .DATA_WIDTH (DATA_WIDTH),
      .REG_NUM    (REG_NUM)
   ) u_regfile (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .raddr1_i (inst_i[19:15]),
      .raddr2_i (inst_i[24:20]),
      .rdata1_o (rs1_data),
      .rdata2_o (rs2_data),
      .we_i     (wb_we_i),
      .waddr_i  (wb_waddr_i),
      .wdata_i  (wb_wdata_i)
   );

   assign inst_ready_o = !ex_valid_o || ex_ready_i;
   assign accept       = inst_valid_i && inst_ready_o;
   assign dec          = decode(inst_i);

   always_comb begin
      op1_d = '0;
      op2_d = '0;
      unique case (1'b1)
         (dec == DEC_ITYPE): begin
            op1_d = rs1_data;
            if (is_shift(inst_i[14:12])) begin
               op2_d = DATA_WIDTH'(inst_i[24:20]);
            end else begin
               op2_d = DATA_WIDTH'($signed(inst_i[31:20]));
            end
         end
         (dec == DEC_RTYPE): begin
            op1_d = rs1_data;
            op2_d = rs2_data;
         end
         default: begin
            op1_d = '0;
            op2_d = '0;
         end
      endcase
   end

   // Reset and flush both park the outputs on a NOP bundle.
   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         ex_valid_o  <= 1'b0;
         op1_o       <= '0;
         op2_o       <= '0;
         inst_o      <= INST_NOP;
         reg_waddr_o <= ZERO;
      end else if (accept) begin
         ex_valid_o  <= 1'b1;
         op1_o       <= op1_d;
         op2_o       <= op2_d;
         inst_o      <= inst_i;
         reg_waddr_o <= inst_i[11:7];
      end else if (ex_ready_i) begin
         ex_valid_o  <= 1'b0;
      end
   end

endmodule
